// File: rtl/cnn_pkg.sv
// Shared types and constants for the classifier stage.
// Holds the logit element type, the most-negative helper and the
// logit_buffer state encoding.
package cnn_pkg;

    // Default logit element width used across the classifier stage.
    localparam int LOGIT_W = 16;

    typedef logic signed [LOGIT_W-1:0] logit_t;

    // Buffer FSM: FILL collects beats, LAUNCH issues start, WAIT holds vec.
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } lbuf_state_t;

    // Most-negative two's-complement value of a w-bit signed number
    // (only bit w-1 set). Callers truncate to their own width.
    function automatic logic [63:0] MOST_NEG(input int w);
        MOST_NEG = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/logit_buffer_if.sv
// Parallel score-vector interface between the dense layer stream,
// the logit buffer and the argmax-style consumer.
// Ports: stream (in_valid/in_ready/in_data/in_last), consumer
// (vec/start/done), status (busy/frame_err).
interface logit_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10
);

    // Serial stream from the dense layer
    logic                               in_valid;
    logic                               in_ready;
    logic signed [DATA_WIDTH-1:0]       in_data;
    logic                               in_last;

    // Parallel side to the consumer
    logic [0:DIM-1][DATA_WIDTH-1:0]     vec;
    logic                               start;
    logic                               done;

    // Status
    logic                               busy;
    logic                               frame_err;

    // Buffer side
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  done,
        output in_ready,
        output vec,
        output start,
        output busy,
        output frame_err
    );

    // Producer/consumer side (dense layer + argmax, or a testbench)
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output done,
        input  in_ready,
        input  vec,
        input  start,
        input  busy,
        input  frame_err
    );

endinterface

// File: rtl/logit_buffer.sv
// Purpose : packs DIM serial signed logits into a parallel vec, then pulses start.
// Latency : final beat at edge N -> start and full vec in cycle N+1; done at edge M -> in_ready in M+1.
// Backpr. : in_ready is low in LAUNCH/WAIT and during reset; stalled beats stay upstream.
//
// Ports:
//   clk      - clock, all logic on posedge
//   reset_n  - synchronous active-low reset
//   bus      - logit_buffer_if.slave: in_valid/in_ready/in_data/in_last stream,
//              vec/start/done consumer handshake, busy/frame_err status
// Build option: define LOGIT_BUF_CLEAR_EN to load vec with the most-negative
// value on reset and on WAIT->FILL, so stale entries never win a max search.
module logit_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
) (
    input  logic             clk,
    input  logic             reset_n,
    logit_buffer_if.slave    bus
);

    generate
        if (DIM < 1) begin : g_bad_dim
            $error("logit_buffer: DIM must be >= 1");
        end
    endgenerate

    localparam logic [1:0]      ST_FILL   = FILL;
    localparam logic [1:0]      ST_LAUNCH = LAUNCH;
    localparam logic [1:0]      ST_WAIT   = WAIT;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DIM - 1);

    logic [1:0]                      state;
    logic [IDXW-1:0]                 wr_ptr;
    logic                            start_q;
    logic                            frame_err_q;
    logic [0:DIM-1][DATA_WIDTH-1:0]  vec_q;
    logic                            accept;

    // in_ready depends only on the state register and reset, never on in_valid.
    assign bus.in_ready  = (state == ST_FILL) && reset_n;
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.vec       = vec_q;
    assign bus.start     = start_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state == ST_LAUNCH) || (state == ST_WAIT);

    // Control FSM, write pointer and registered pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_FILL;
            wr_ptr      <= '0;
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (wr_ptr == LAST_IDX) begin
                            // Full frame: launch even if in_last is missing,
                            // but flag the framing problem.
                            state       <= ST_LAUNCH;
                            wr_ptr      <= '0;
                            start_q     <= 1'b1;
                            frame_err_q <= ~bus.in_last;
                        end else if (bus.in_last) begin
                            // Early last: drop the partial frame and restart.
                            wr_ptr      <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            wr_ptr      <= wr_ptr + 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.done) begin
                        state <= ST_FILL;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    // Element storage. vec only moves on accepted beats (and, with the
    // clear option, on reset / buffer release), so it is frozen from
    // start until the next accepted beat.
`ifdef LOGIT_BUF_CLEAR_EN
    localparam logic [DATA_WIDTH-1:0] MOST_NEG_V = DATA_WIDTH'(MOST_NEG(DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (!reset_n || ((state == ST_WAIT) && bus.done)) begin
            for (int i = 0; i < DIM; i++) begin
                vec_q[i] <= MOST_NEG_V;
            end
        end else begin
            for (int i = 0; i < DIM; i++) begin
                if (accept && (wr_ptr == IDXW'(i))) begin
                    vec_q[i] <= bus.in_data;
                end
            end
        end
    end
`else
    // No reset or clear on the element storage: contents stay stale until
    // overwritten.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DIM; i++) begin
            if (accept && (wr_ptr == IDXW'(i))) begin
                vec_q[i] <= bus.in_data;
            end
        end
    end
`endif

endmodule
